// File: rtl/period_meter_if.sv
// Measurement bundle for period_meter: the sampled square wave in, period/high-time results out.
interface period_meter_if #(
  parameter int WIDTH = 16
) ();
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic             period_vld;
  logic [WIDTH-1:0] high_time;
  logic             timeout;
  logic             busy;

  modport slave (
    input  sig_in,
    output period, period_vld, high_time, timeout, busy
  );

  modport master (
    output sig_in,
    input  period, period_vld, high_time, timeout, busy
  );
endinterface

// File: rtl/period_meter.sv
// Period meter: counts clock cycles between synchronized rising edges of sig_in.
// Define PERIOD_METER_HIGH_TIME_EN to also measure the high time within each period.
module period_meter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 2**WIDTH - 1
) (
  input  logic          cLocK,
  input  logic          Reset,
  period_meter_if.slave pm
);

  localparam logic [WIDTH-1:0] TO_V = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic             rise;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

  // s2_q is the synchronized level; prev_q delays it one more cycle for edge detection
  assign rise = s2_q & ~prev_q;

  always_ff @(posedge cLocK) begin
    if (Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      s1_q     <= pm.sig_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end
      end
      MEASURE: begin
        // a rise on the timeout cycle still counts as a valid measurement
        if (rise) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          to_d     = 1'b0;
          cnt_d    = ONE;
        end else if (cnt_q == TO_V) begin
          state_d = IDLE;
          to_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_q, high_d;

  always_ff @(posedge cLocK) begin
    if (Reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  // high count never exceeds the cycle count, so it cannot wrap either
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (rise) hcnt_d = ONE;
      end
      MEASURE: begin
        if (rise) begin
          high_d = hcnt_q;
          hcnt_d = ONE;
        end else if (cnt_q == TO_V) begin
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + WIDTH'(s2_q);
        end
      end
      default: hcnt_d = '0;
    endcase
  end

  assign pm.high_time = high_q;
`else
  assign pm.high_time = '0;
`endif

  assign pm.period     = period_q;
  assign pm.period_vld = vld_q;
  assign pm.timeout    = to_q;
  assign pm.busy       = (state_q == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random waves against a timestamp model.
module tb_period_meter;
  localparam int W    = 8;
  localparam int TO   = 20;
  localparam int MAXC = 20000;
`ifdef PERIOD_METER_HIGH_TIME_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic cLocK = 1'b0;
  logic Reset;
  period_meter_if #(.WIDTH(W)) pm ();

  period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .cLocK (cLocK),
    .Reset (Reset),
    .pm    (pm.slave)
  );

  always #5 cLocK = ~cLocK;

  int n_chk = 0;
  int n_err = 0;

  // model: u[k] = level captured by the first sync flop at edge k (0 under reset)
  int u [0:MAXC];
  int e;
  bit armed;
  int last_rise;
  int m_per, m_high, m_vld, m_to;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", tag, e, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic r);
    bit rise;
    int d, hs;
    @(negedge cLocK);
    pm.sig_in = s;
    Reset     = r;
    @(posedge cLocK);
    e++;
    if (e >= MAXC) begin
      $display("FAIL cycle_budget: edge %0d, limit %0d", e, MAXC);
      $fatal(1);
    end
    m_vld = 0;
    if (r) begin
      u[e] = 0; u[e-1] = 0;
      armed = 0; m_per = 0; m_high = 0; m_to = 0;
    end else begin
      u[e] = int'(s);
      // the synchronized level seen by the meter at edge e is what was captured two edges earlier
      rise = (u[e-2] == 1) && (u[e-3] == 0);
      if (armed) begin
        d = e - last_rise;
        if (rise) begin
          hs = 0;
          for (int j = last_rise; j < e; j++) hs += u[j-2];
          m_per = d; m_high = HI_EN ? hs : 0;
          m_vld = 1; m_to = 0; last_rise = e;
        end else if (d == TO) begin
          armed = 0; m_to = 1;
        end
      end else if (rise) begin
        armed = 1; last_rise = e;
      end
    end
    #1;
    chk("period",     int'(pm.period),     m_per);
    chk("high_time",  int'(pm.high_time),  m_high);
    chk("period_vld", int'(pm.period_vld), m_vld);
    chk("timeout",    int'(pm.timeout),    m_to);
    chk("busy",       int'(pm.busy),       int'(armed));
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (hi) step(1'b1, 1'b0);
      repeat (lo) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k <= MAXC; k++) u[k] = 0;
    e = 3; armed = 0; last_rise = 0;
    m_per = 0; m_high = 0; m_vld = 0; m_to = 0;
    pm.sig_in = 1'b0;
    Reset     = 1'b1;

    repeat (3) step(1'b0, 1'b1);
    chk("rst_period", int'(pm.period), 0);
    chk("rst_busy",   int'(pm.busy),   0);

    // 3 high / 3 low
    wave(3, 3, 6);
    chk("w33_period", int'(pm.period),    6);
    chk("w33_high",   int'(pm.high_time), HI_EN ? 3 : 0);
    chk("w33_busy",   int'(pm.busy),      1);

    // toggling every cycle: minimum period
    wave(1, 1, 10);
    chk("tog_period", int'(pm.period),    2);
    chk("tog_high",   int'(pm.high_time), HI_EN ? 1 : 0);

    // single rise then held low: timeout
    step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);
    chk("to_flag",   int'(pm.timeout), 1);
    chk("to_busy",   int'(pm.busy),    0);
    chk("to_period", int'(pm.period),  2);

    // rises exactly TIMEOUT apart: rise wins
    wave(1, TO - 1, 5);
    chk("tob_period", int'(pm.period),  TO);
    chk("tob_flag",   int'(pm.timeout), 0);

    // period-10 wave with reset mid-measurement
    repeat (2) step(1'b0, 1'b1);
    wave(5, 5, 3);
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    wave(5, 5, 3);
    chk("rstm_period", int'(pm.period), 10);

    // high level while reset releases is seen as a rise three cycles later
    repeat (2) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    chk("rel_busy2", int'(pm.busy), 0);
    step(1'b1, 1'b0);
    chk("rel_busy3", int'(pm.busy), 1);
    repeat (3) step(1'b0, 1'b0);

    // random waves, occasional long lows around the timeout and occasional resets
    for (int it = 0; it < 400; it++) begin
      int hi, lo;
      hi = $urandom_range(1, 10);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 3, TO + 5) - hi
                                      : $urandom_range(1, 10);
      if (lo < 1) lo = 1;
      if ($urandom_range(0, 39) == 0) step(1'($urandom_range(0, 1)), 1'b1);
      wave(hi, lo, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
